// File: rtl/clock_divider_bank_if.sv
// Divisor configuration bus for clock_divider_bank: one write strobe carrying
// a channel index and a new half-period value.
interface clock_divider_bank_if #(
    parameter int CNT_W = 32
) ();
    logic             cfg_valid;
    logic [2:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_half;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_half
    );

    modport slave (
        input cfg_valid,
        input cfg_ch,
        input cfg_half
    );
endinterface

// File: rtl/clock_divider_bank.sv
// Bank of NUM_CH independent programmable clock dividers with registered
// divided clocks, tick strobes and boundary-aligned divisor updates.
module clock_divider_bank #(
    parameter int               NUM_CH     = 2,
    parameter int               CNT_W      = 32,
    parameter logic [CNT_W-1:0] RESET_HALF = 50
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   en,
    clock_divider_bank_if.slave cfg,
    output logic [NUM_CH-1:0]   div_clk,
    output logic [NUM_CH-1:0]   tick,
    output logic [NUM_CH-1:0]   tick_rise,
    output logic [NUM_CH-1:0]   pending
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] hp;
        logic [CNT_W-1:0] nxt;
        logic             pend_r;
        logic             div_r;
        logic             tick_r;
        logic             rise_r;
        logic             wr;
        logic             tc;

        // cfg_ch is compared at full width, so indices >= NUM_CH never match
        assign wr = cfg.cfg_valid && (cfg.cfg_ch == 3'(g));
        assign tc = en[g] && (cnt == hp);

        always_ff @(posedge clock) begin
            if (reset) begin
                cnt    <= '0;
                hp     <= RESET_HALF;
                nxt    <= '0;
                pend_r <= 1'b0;
                div_r  <= 1'b0;
                tick_r <= 1'b0;
                rise_r <= 1'b0;
            end else if (!en[g]) begin
                cnt    <= '0;
                div_r  <= 1'b0;
                tick_r <= 1'b0;
                rise_r <= 1'b0;
                // stopped: writes land directly, and a parked divisor is committed
                if (wr) begin
                    hp     <= cfg.cfg_half;
                    pend_r <= 1'b0;
                end else if (pend_r) begin
                    hp     <= nxt;
                    pend_r <= 1'b0;
                end
            end else if (tc) begin
                cnt    <= '0;
                div_r  <= ~div_r;
                tick_r <= 1'b1;
                rise_r <= ~div_r;
                // boundary: a same-cycle write overrides any parked value
                if (wr) begin
                    hp     <= cfg.cfg_half;
                    pend_r <= 1'b0;
                end else if (pend_r) begin
                    hp     <= nxt;
                    pend_r <= 1'b0;
                end
            end else begin
                cnt    <= cnt + 1'b1;
                tick_r <= 1'b0;
                rise_r <= 1'b0;
                if (wr) begin
                    nxt    <= cfg.cfg_half;
                    pend_r <= 1'b1;
                end
            end
        end

        assign div_clk[g]   = div_r;
        assign tick[g]      = tick_r;
        assign tick_rise[g] = rise_r;
        assign pending[g]   = pend_r;
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank: timed check table for the running
// scenarios plus hand-written disable/re-enable and reset sequences.
module tb_clock_divider_bank;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] div_clk;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] tick_rise;
    logic [NUM_CH-1:0] pending;

    clock_divider_bank_if #(.CNT_W(CNT_W)) cfg_bus ();

    clock_divider_bank #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .RESET_HALF(32'd50)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .cfg      (cfg_bus),
        .div_clk  (div_clk),
        .tick     (tick),
        .tick_rise(tick_rise),
        .pending  (pending)
    );

    always #5 clock = ~clock;

    // One record: at step t, compare channel ch against {div,tick,rise,pend};
    // if wr is set, then drive a divisor write to ch for the next edge.
    typedef struct {
        int          t;
        logic        wr;
        logic [31:0] whalf;
        int          ch;
        logic [3:0]  exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   t_now  = 0;

    function automatic vec_t mk(int t, logic wr, logic [31:0] whalf, int ch, logic [3:0] exp);
        vec_t v;
        v.t = t; v.wr = wr; v.whalf = whalf; v.ch = ch; v.exp = exp;
        return v;
    endfunction

    function automatic logic [3:0] ch_out(int ch);
        return {div_clk[ch], tick[ch], tick_rise[ch], pending[ch]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, got, exp, t_now);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        t_now++;
    endtask

    task automatic step_to(input int target);
        while (t_now < target) step();
    endtask

    task automatic chk_ch(input string name, input int ch, input logic [3:0] exp);
        check($sformatf("%s_ch%0d", name, ch), 32'(ch_out(ch)), 32'(exp));
    endtask

    int tick0_cnt, rise0_cnt, high1_cnt, tick1_cnt, pend_seen;

    initial begin
        // Timeline with en=2'b11 driven at t=0 (t=1 is the first enabled edge).
        // ch0 hp=50: transitions at multiples of 51. ch1 hp=3: every 4 edges.
        vecs.push_back(mk(  3, 1'b0, 0, 1, 4'b0000));
        vecs.push_back(mk(  4, 1'b0, 0, 1, 4'b1110));
        vecs.push_back(mk(  5, 1'b0, 0, 1, 4'b1000));
        vecs.push_back(mk(  7, 1'b0, 0, 1, 4'b1000));
        vecs.push_back(mk(  8, 1'b0, 0, 1, 4'b0100));
        vecs.push_back(mk( 12, 1'b0, 0, 1, 4'b1110));
        vecs.push_back(mk( 50, 1'b0, 0, 0, 4'b0000));
        vecs.push_back(mk( 51, 1'b0, 0, 0, 4'b1110));
        vecs.push_back(mk( 52, 1'b0, 0, 0, 4'b1000));
        vecs.push_back(mk(100, 1'b0, 0, 1, 4'b1110));
        vecs.push_back(mk(101, 1'b0, 0, 0, 4'b1000));
        vecs.push_back(mk(102, 1'b0, 0, 0, 4'b0100));
        vecs.push_back(mk(103, 1'b0, 0, 0, 4'b0000));
        vecs.push_back(mk(104, 1'b0, 0, 1, 4'b0100));
        // deferred writes at cnt=20 (H=9) and cnt=30 (H=4); last one wins at TC 204
        vecs.push_back(mk(173, 1'b1, 9, 0, 4'b1000));
        vecs.push_back(mk(174, 1'b0, 0, 0, 4'b1001));
        vecs.push_back(mk(183, 1'b1, 4, 0, 4'b1001));
        vecs.push_back(mk(184, 1'b0, 0, 0, 4'b1001));
        vecs.push_back(mk(203, 1'b0, 0, 0, 4'b1001));
        vecs.push_back(mk(204, 1'b0, 0, 0, 4'b0100));
        vecs.push_back(mk(208, 1'b0, 0, 0, 4'b0000));
        vecs.push_back(mk(208, 1'b0, 0, 1, 4'b0100));
        vecs.push_back(mk(209, 1'b0, 0, 0, 4'b1110));
        vecs.push_back(mk(212, 1'b0, 0, 1, 4'b1110));
        vecs.push_back(mk(214, 1'b0, 0, 0, 4'b0100));
        // H=0 written so it lands on the TC at edge 219
        vecs.push_back(mk(218, 1'b1, 0, 0, 4'b0000));
        vecs.push_back(mk(219, 1'b0, 0, 0, 4'b1110));
        vecs.push_back(mk(220, 1'b0, 0, 0, 4'b0100));
        vecs.push_back(mk(221, 1'b0, 0, 0, 4'b1110));
        vecs.push_back(mk(222, 1'b0, 0, 0, 4'b0100));

        reset = 1'b1;
        en    = '0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_ch    = '0;
        cfg_bus.cfg_half  = '0;
        repeat (3) step();
        chk_ch("reset", 0, 4'b0000);
        chk_ch("reset", 1, 4'b0000);
        reset = 1'b0;
        step();

        // ch1 stopped: write lands directly
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ch    = 3'd1;
        cfg_bus.cfg_half  = 32'd3;
        step();
        cfg_bus.cfg_valid = 1'b0;
        check("stopped_write_pending", 32'(pending), 32'd0);

        en = 2'b11;
        t_now = 0;
        tick0_cnt = 0; rise0_cnt = 0; high1_cnt = 0; tick1_cnt = 0; pend_seen = 0;

        while (t_now < 222) begin
            step();
            cfg_bus.cfg_valid = 1'b0;
            if (t_now <= 110) begin
                tick0_cnt += int'(tick[0]);
                rise0_cnt += int'(tick_rise[0]);
                pend_seen += int'(pending[1]) + int'(pending[0]);
            end
            if (t_now <= 104) begin
                high1_cnt += int'(div_clk[1]);
                tick1_cnt += int'(tick[1]);
            end
            foreach (vecs[i]) begin
                if (vecs[i].t == t_now) begin
                    chk_ch($sformatf("vec_t%0d", t_now), vecs[i].ch, vecs[i].exp);
                    if (vecs[i].wr) begin
                        cfg_bus.cfg_valid = 1'b1;
                        cfg_bus.cfg_ch    = 3'(vecs[i].ch);
                        cfg_bus.cfg_half  = vecs[i].whalf;
                    end
                end
            end
            if (t_now == 110) begin
                check("ch0_tick_count", 32'(tick0_cnt), 32'd2);
                check("ch0_rise_count", 32'(rise0_cnt), 32'd1);
                check("pending_idle", 32'(pend_seen), 32'd0);
            end
            if (t_now == 104) begin
                check("ch1_high_cycles", 32'(high1_cnt), 32'd52);
                check("ch1_tick_count", 32'(tick1_cnt), 32'd26);
            end
        end

        // ch0 at hp=0: any write hits TC, so H=5 takes effect at edge 223
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ch    = 3'd0;
        cfg_bus.cfg_half  = 32'd5;
        step();
        cfg_bus.cfg_valid = 1'b0;
        chk_ch("h5_at_tc", 0, 4'b1110);
        step();
        chk_ch("h5_count", 0, 4'b1000);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_half  = 32'd7;
        step();
        cfg_bus.cfg_valid = 1'b0;
        chk_ch("nxt7_pending", 0, 4'b1001);
        step();
        chk_ch("nxt7_hold", 0, 4'b1001);
        en = 2'b10;
        step();
        chk_ch("disable", 0, 4'b0000);
        step_to(229);
        en = 2'b11;
        step_to(236);
        chk_ch("reenable_pre", 0, 4'b0000);
        step();
        chk_ch("reenable_rise", 0, 4'b1110);
        step_to(244);
        chk_ch("reenable_high", 0, 4'b1000);
        step();
        chk_ch("reenable_fall", 0, 4'b0100);
        step_to(253);
        chk_ch("reenable_rise2", 0, 4'b1110);

        // reset mid-period together with an out-of-range write
        step_to(258);
        reset = 1'b1;
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ch    = 3'd5;
        cfg_bus.cfg_half  = 32'd3;
        step();
        chk_ch("midreset", 0, 4'b0000);
        chk_ch("midreset", 1, 4'b0000);
        reset = 1'b0;
        step();
        cfg_bus.cfg_valid = 1'b0;
        check("oob_write_pending", 32'(pending), 32'd0);
        step_to(309);
        check("post_reset_pre_rise", 32'(div_clk), 32'd0);
        step();
        chk_ch("post_reset_rise", 0, 4'b1110);
        chk_ch("post_reset_rise", 1, 4'b1110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_divider_bank.md
# clock_divider_bank

Multi-channel programmable clock-enable and divided-clock generator. It replaces the fixed divide-by-102 toggle counter in the board top level with NUM_CH independent channels. Each channel has a run-time programmable half-period, a per-channel enable, and glitch-free divisor updates applied only at period boundaries. It sits in the board interface layer and feeds divided clocks and single-cycle tick strobes to the chip-under-test and the peripherals (UART baud, PWM, I2C timing).

## Interface
- NUM_CH, 2: number of independent divider channels (1..8)
- CNT_W, 32: width of the half-period counter and divisor registers
- RESET_HALF, 50: half-period value loaded into every channel at reset (gives 100 MHz / 102)
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- en  in  NUM_CH  per-channel run enable
- cfg_valid  in  1  divisor write strobe, one cycle per write
- cfg_ch  in  3  target channel index; values >= NUM_CH are ignored
- cfg_half  in  CNT_W  new half-period value H; each half period lasts H+1 cycles
- div_clk  out  NUM_CH  divided clock per channel, 50% duty, registered
- tick  out  NUM_CH  one-cycle strobe on every div_clk transition
- tick_rise  out  NUM_CH  one-cycle strobe on 0->1 transitions only
- pending  out  NUM_CH  a written divisor is waiting for the next boundary

## Operation
- Each channel has the following state:
  - cnt[CNT_W]: counter
  - hp[CNT_W]: active half-period
  - nxt[CNT_W]: pending half-period
  - pend: pending flag
  - div_clk, tick and tick_rise registers
- Terminal count (TC): en=1 and cnt==hp.
- Running (en=1):
  - When not TC: cnt<=cnt+1, tick<=0, tick_rise<=0.
  - At TC: cnt<=0, div_clk<=~div_clk, tick<=1, tick_rise<=~div_clk (the old value).
- Output period is 2*(hp+1) cycles. hp=0 toggles every cycle, with tick held high continuously.
- Stopped (en=0):
  - cnt<=0, div_clk<=0, tick<=0, tick_rise<=0.
  - hp is retained.
- Divisor write (cfg_valid=1, cfg_ch<NUM_CH) goes to the addressed channel:
  - Channel running and not at TC: nxt<=cfg_half, pend<=1. A second write before the boundary overwrites nxt, and the last write wins.
  - Channel at TC in the same cycle: hp<=cfg_half directly, pend stays/becomes 0. The write bypasses pending, and the new value governs the half period starting now.
  - Channel stopped: hp<=cfg_half immediately, pend<=0.
- Pending apply: at TC with pend=1 and no same-cycle write, hp<=nxt and pend<=0.
- A write never truncates or stretches the half period in progress. cnt is always 0 when hp changes while running, so no overshoot or wrap is possible.
- Disable with pend=1: on the first en=0 cycle, hp<=nxt and pend<=0.
- cnt never exceeds hp. The CNT_W counter never wraps.
- Channels are fully independent. A write only affects cfg_ch.

## Timing
- Reset values:
  - cnt=0, hp=RESET_HALF, nxt=0, pend=0.
  - div_clk=0, tick=0, tick_rise=0 on all channels.
- Reset has priority over en and cfg_valid in the same cycle.
- Reset asserted mid-period aborts the period; outputs read reset values on the next cycle.
- Enable latency:
  - en rises at edge E0. The first div_clk 0->1 (with tick=tick_rise=1) is visible after edge E0+hp+1.
  - The next transition follows hp+1 cycles later.
- Disable latency: div_clk reads 0 one cycle after en samples low.
- pending is a register: it rises the cycle after an accepted deferred write and falls the cycle after the applying TC.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset then en[0]=1 with default RESET_HALF=50:
  - div_clk[0] rises 51 cycles after enable and has period 102.
  - tick[0] is high exactly once per 51 cycles.
  - tick_rise[0] is high once per 102 cycles.
- cfg write ch1 H=3 while ch1 is stopped, then en[1]=1:
  - pending[1] never asserts.
  - div_clk[1] has period 8, with 4 high and 4 low cycles.
- ch0 running with H=50; write H=9 at cnt=20, then write H=4 at cnt=30:
  - pending[0] is 1 until TC.
  - The current half period stays 51 cycles, then subsequent halves are 5 cycles.
  - ch1 is unaffected.
- Write H=0 to ch0 in the same cycle as its TC:
  - The next half period is 1 cycle.
  - div_clk toggles every cycle and tick stays high.
  - pending[0] stays 0.
- Drop en[0] mid-period with pend=1 (nxt=7):
  - div_clk[0]=0 next cycle.
  - Re-enable: the first rise comes 8 cycles later with period 16.
- Assert reset mid-operation with hp=7 and cfg_valid=1, cfg_ch=5 on a 2-channel build:
  - All outputs return to 0 and hp returns to 50.
  - The out-of-range write has no effect.
